// File: rtl/regfile_write_arbiter_if.sv
// Signal bundle between the core writeback path, the host poke port and the
// register database write port that the arbiter multiplexes.
interface regfile_write_arbiter_if;
  logic        coreRegWrite;
  logic [4:0]  coreWriteRegister;
  logic [31:0] coreWriteData;
  logic        hostValid;
  logic        hostReady;
  logic [4:0]  hostRegister;
  logic [31:0] hostData;
  logic        hostDone;
  logic        coreStall;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;

  modport master (
    output coreRegWrite, coreWriteRegister, coreWriteData,
    output hostValid, hostRegister, hostData,
    input  hostReady, hostDone, coreStall,
    input  regWrite, writeRegister, writeData
  );

  modport slave (
    input  coreRegWrite, coreWriteRegister, coreWriteData,
    input  hostValid, hostRegister, hostData,
    output hostReady, hostDone, coreStall,
    output regWrite, writeRegister, writeData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Core-priority arbiter for the register database write port with a one-entry
// host buffer and starvation-forced host writes. REGFILE_ARB_STATS_EN adds counters.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned WAIT_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [31:0]            hostWriteCount,
  output logic [31:0]            forcedStallCount
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FORCE   = 2'd2
  } state_e;

  localparam logic [WAIT_WIDTH-1:0] LIMIT = WAIT_WIDTH'(STARVE_LIMIT);
  localparam logic [WAIT_WIDTH-1:0] ONE   = {{(WAIT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [4:0]            buf_addr_q, buf_addr_d;
  logic [31:0]           buf_data_q, buf_data_d;
  logic [WAIT_WIDTH-1:0] wait_q, wait_d;
  logic                  host_done_q, host_done_d;
  logic                  host_slot_s;
  logic [WAIT_WIDTH-1:0] wait_inc_s;

  assign wait_inc_s  = (wait_q >= LIMIT) ? LIMIT : (wait_q + ONE);
  // The buffer owns the port when the core is idle in PENDING, or unconditionally in FORCE.
  assign host_slot_s = ((state_q == PENDING) && !bus.coreRegWrite) || (state_q == FORCE);

  // Next-state, buffer capture and starvation counting.
  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    wait_d      = wait_q;
    host_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.hostValid) begin
          buf_addr_d = bus.hostRegister;
          buf_data_d = bus.hostData;
          wait_d     = '0;
          state_d    = PENDING;
        end else begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        if (!bus.coreRegWrite) begin
          state_d     = IDLE;
          host_done_d = 1'b1;
        end else begin
          wait_d = wait_inc_s;
          if (wait_inc_s == LIMIT) begin
            state_d = FORCE;
          end else begin
            state_d = PENDING;
          end
        end
      end
      FORCE: begin
        state_d     = IDLE;
        host_done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-port mux; a buffered write to register 0 keeps its slot but is not enabled.
  always_comb begin
    bus.regWrite      = bus.coreRegWrite;
    bus.writeRegister = bus.coreWriteRegister;
    bus.writeData     = bus.coreWriteData;
    if (host_slot_s) begin
      bus.regWrite      = (buf_addr_q != 5'd0);
      bus.writeRegister = buf_addr_q;
      bus.writeData     = buf_data_q;
    end else begin
      bus.regWrite      = bus.coreRegWrite;
      bus.writeRegister = bus.coreWriteRegister;
      bus.writeData     = bus.coreWriteData;
    end
  end

  assign bus.hostReady = (state_q == IDLE);
  assign bus.coreStall = (state_q == FORCE);
  assign bus.hostDone  = host_done_q;

  // FSM state, buffer and handshake flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      buf_addr_q  <= 5'd0;
      buf_data_q  <= 32'd0;
      wait_q      <= '0;
      host_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      wait_q      <= wait_d;
      host_done_q <= host_done_d;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] host_cnt_q, host_cnt_d;
  logic [31:0] force_cnt_q, force_cnt_d;

  // Host count moves together with the hostDone pulse; forced count at the end of FORCE.
  always_comb begin
    host_cnt_d  = host_done_d ? (host_cnt_q + 32'd1) : host_cnt_q;
    force_cnt_d = (state_q == FORCE) ? (force_cnt_q + 32'd1) : force_cnt_q;
  end

  // Statistics counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_cnt_q  <= 32'd0;
      force_cnt_q <= 32'd0;
    end else begin
      host_cnt_q  <= host_cnt_d;
      force_cnt_q <= force_cnt_d;
    end
  end

  assign hostWriteCount   = host_cnt_q;
  assign forcedStallCount = force_cnt_q;
`endif

endmodule
